alu_arbiter: RTL and testbench

- Shares the single 32-bit ALU between two requesters: requester 0 is the main execute stage, requester 1 is an auxiliary address/branch-target unit.
- Each requester issues {A, B, ALUop} over a valid/ready handshake.
- The arbiter grants at most one requester per cycle using round-robin priority, and drives the ALU operands combinationally.
- The ALU result is captured into a per-requester one-entry response buffer, which is drained by its own valid/ready handshake.

---
 rtl/alu_arb_pkg.sv | 13 +
 rtl/alu_arbiter_rsp_slot.sv | 46 ++++
 rtl/alu_arbiter.sv | 101 ++++++++++
 tb/tb_alu_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arb_pkg.sv
// Shared constants for the two-requester ALU arbiter.
// ALUop encodings live in the ALU decoder header and are intentionally not repeated here.
package alu_arb_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int OPW_DEF   = 4;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  localparam logic [OPW_DEF-1:0] ALU_IDLE_OP = 4'b0;

endpackage

// File: rtl/alu_arbiter_rsp_slot.sv
// One-entry response buffer: captures a result on load, releases it on resp_ready.
// A load in the same cycle as a drain refills the slot with no gap in resp_valid.
module rsp_slot
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             resp_ready,
  output logic             resp_valid,
  output logic [WIDTH-1:0] resp_data,
  output logic             can_accept
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q,  data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = data_in;
    end else if (resp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign resp_valid = valid_q;
  assign resp_data  = data_q;
  assign can_accept = !valid_q || resp_ready;

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between the execute stage (r0) and the
// address/branch-target unit (r1), with a one-cycle registered result per requester.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int OPW   = OPW_DEF
) (
  input  logic             Clock,
  input  logic             Reset,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [WIDTH-1:0] r0_A,
  input  logic [WIDTH-1:0] r0_B,
  input  logic [OPW-1:0]   r0_ALUop,
  output logic             r0_resp_valid,
  input  logic             r0_resp_ready,
  output logic [WIDTH-1:0] r0_resp_data,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [WIDTH-1:0] r1_A,
  input  logic [WIDTH-1:0] r1_B,
  input  logic [OPW-1:0]   r1_ALUop,
  output logic             r1_resp_valid,
  input  logic             r1_resp_ready,
  output logic [WIDTH-1:0] r1_resp_data,

  output logic [WIDTH-1:0] alu_A,
  output logic [WIDTH-1:0] alu_B,
  output logic [OPW-1:0]   alu_ALUop,
  input  logic [WIDTH-1:0] alu_Out
);

  logic rr_ptr_q, rr_ptr_d;
  logic can0, can1;
  logic elig0, elig1;
  logic grant0, grant1;

  // Reset gates eligibility so ready is low throughout reset.
  assign elig0 = r0_valid && can0 && !Reset;
  assign elig1 = r1_valid && can1 && !Reset;

  always_comb begin
    grant0 = elig0 && (!elig1 || (rr_ptr_q == REQ0));
    grant1 = elig1 && (!elig0 || (rr_ptr_q == REQ1));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant0)      rr_ptr_d = REQ1;
    else if (grant1) rr_ptr_d = REQ0;
  end

  always_ff @(posedge Clock) begin
    if (Reset) rr_ptr_q <= REQ0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign r0_ready = grant0;
  assign r1_ready = grant1;

  always_comb begin
    alu_A     = '0;
    alu_B     = '0;
    alu_ALUop = OPW'(ALU_IDLE_OP);
    if (grant0) begin
      alu_A     = r0_A;
      alu_B     = r0_B;
      alu_ALUop = r0_ALUop;
    end else if (grant1) begin
      alu_A     = r1_A;
      alu_B     = r1_B;
      alu_ALUop = r1_ALUop;
    end
  end

  rsp_slot #(.WIDTH(WIDTH)) u_slot0 (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (grant0),
    .data_in    (alu_Out),
    .resp_ready (r0_resp_ready),
    .resp_valid (r0_resp_valid),
    .resp_data  (r0_resp_data),
    .can_accept (can0)
  );

  rsp_slot #(.WIDTH(WIDTH)) u_slot1 (
    .Clock      (Clock),
    .Reset      (Reset),
    .load       (grant1),
    .data_in    (alu_Out),
    .resp_ready (r1_resp_ready),
    .resp_valid (r1_resp_valid),
    .resp_data  (r1_resp_data),
    .can_accept (can1)
  );

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the shared port.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_XOR = 4'b0100;

  logic        Clock, Reset;
  logic        r0_valid, r0_ready, r0_resp_valid, r0_resp_ready;
  logic [31:0] r0_A, r0_B, r0_resp_data;
  logic [3:0]  r0_ALUop;
  logic        r1_valid, r1_ready, r1_resp_valid, r1_resp_ready;
  logic [31:0] r1_A, r1_B, r1_resp_data;
  logic [3:0]  r1_ALUop;
  logic [31:0] alu_A, alu_B, alu_Out;
  logic [3:0]  alu_ALUop;

  int n_cmp = 0;
  int n_err = 0;

  alu_arbiter dut (
    .Clock(Clock), .Reset(Reset),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_A(r0_A), .r0_B(r0_B),
    .r0_ALUop(r0_ALUop), .r0_resp_valid(r0_resp_valid),
    .r0_resp_ready(r0_resp_ready), .r0_resp_data(r0_resp_data),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_A(r1_A), .r1_B(r1_B),
    .r1_ALUop(r1_ALUop), .r1_resp_valid(r1_resp_valid),
    .r1_resp_ready(r1_resp_ready), .r1_resp_data(r1_resp_data),
    .alu_A(alu_A), .alu_B(alu_B), .alu_ALUop(alu_ALUop), .alu_Out(alu_Out)
  );

  always_comb begin
    case (alu_ALUop)
      ALU_ADD: alu_Out = alu_A + alu_B;
      ALU_XOR: alu_Out = alu_A ^ alu_B;
      default: alu_Out = 32'h0;
    endcase
  end

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic mid();
    @(negedge Clock);
  endtask

  task automatic set_r0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    r0_valid = v; r0_A = a; r0_B = b; r0_ALUop = op;
  endtask

  task automatic set_r1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    r1_valid = v; r1_A = a; r1_B = b; r1_ALUop = op;
  endtask

  logic [31:0] exp0, exp1;
  int cnt0, cnt1;

  initial begin
    Reset = 1'b1;
    set_r0(1'b1, 32'h0, 32'h0, 4'h0);
    set_r1(1'b1, 32'h0, 32'h0, 4'h0);
    r0_resp_ready = 1'b1;
    r1_resp_ready = 1'b1;

    // reset state, ready forced low despite valid
    tick(); mid();
    chk("rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("rst_r1_ready", 32'(r1_ready), 32'd0);
    chk("rst_r0_rvalid", 32'(r0_resp_valid), 32'd0);
    chk("rst_r1_rvalid", 32'(r1_resp_valid), 32'd0);
    chk("rst_r0_rdata", r0_resp_data, 32'h0);
    chk("rst_r1_rdata", r1_resp_data, 32'h0);

    // 1: single requester ADD
    tick(); Reset = 1'b0;
    set_r0(1'b1, 32'h5, 32'h3, ALU_ADD); r1_valid = 1'b0;
    mid();
    chk("t1_r0_ready", 32'(r0_ready), 32'd1);
    chk("t1_r1_ready", 32'(r1_ready), 32'd0);
    chk("t1_alu_A", alu_A, 32'h5);
    chk("t1_alu_B", alu_B, 32'h3);
    chk("t1_alu_op", 32'(alu_ALUop), 32'(ALU_ADD));
    tick(); r0_valid = 1'b0;
    mid();
    chk("t1_rvalid", 32'(r0_resp_valid), 32'd1);
    chk("t1_rdata", r0_resp_data, 32'h8);
    tick(); mid();
    chk("t1_drain_rvalid", 32'(r0_resp_valid), 32'd0);
    chk("t1_drain_hold", r0_resp_data, 32'h8);

    // 2: simultaneous requests after reset
    tick(); Reset = 1'b1;
    tick(); Reset = 1'b0;
    set_r0(1'b1, 32'hFFFF_0000, 32'h0F0F_0F0F, ALU_XOR);
    set_r1(1'b1, 32'h1, 32'h1, ALU_ADD);
    mid();
    chk("t2_r0_ready", 32'(r0_ready), 32'd1);
    chk("t2_r1_ready", 32'(r1_ready), 32'd0);
    chk("t2_alu_A", alu_A, 32'hFFFF_0000);
    tick(); r0_valid = 1'b0;
    mid();
    chk("t2_r1_ready2", 32'(r1_ready), 32'd1);
    chk("t2_alu_A2", alu_A, 32'h1);
    chk("t2_r0_rvalid", 32'(r0_resp_valid), 32'd1);
    chk("t2_r0_rdata", r0_resp_data, 32'hF0F0_0F0F);
    tick(); r1_valid = 1'b0;
    mid();
    chk("t2_r1_rvalid", 32'(r1_resp_valid), 32'd1);
    chk("t2_r1_rdata", r1_resp_data, 32'h2);

    // 3: continuous contention, pointer starts at r0
    cnt0 = 0; cnt1 = 0; exp0 = 32'h0; exp1 = 32'h0;
    for (int i = 0; i < 8; i++) begin
      tick();
      set_r0(1'b1, 32'(i), 32'd100, ALU_ADD);
      set_r1(1'b1, 32'(i), 32'hFF, ALU_XOR);
      mid();
      chk($sformatf("t3_r0_ready_%0d", i), 32'(r0_ready), 32'((i % 2) == 0));
      chk($sformatf("t3_r1_ready_%0d", i), 32'(r1_ready), 32'((i % 2) == 1));
      if (r0_resp_valid) begin cnt0++; chk($sformatf("t3_r0_data_%0d", i), r0_resp_data, exp0); end
      if (r1_resp_valid) begin cnt1++; chk($sformatf("t3_r1_data_%0d", i), r1_resp_data, exp1); end
      if ((i % 2) == 0) exp0 = 32'(i) + 32'd100;
      else              exp1 = 32'(i) ^ 32'hFF;
    end
    tick(); r0_valid = 1'b0; r1_valid = 1'b0;
    mid();
    if (r0_resp_valid) begin cnt0++; chk("t3_r0_data_end", r0_resp_data, exp0); end
    if (r1_resp_valid) begin cnt1++; chk("t3_r1_data_end", r1_resp_data, exp1); end
    chk("t3_r0_count", 32'(cnt0), 32'd4);
    chk("t3_r1_count", 32'(cnt1), 32'd4);

    // 4: r0 slot full and stalled; r1 keeps winning regardless of pointer
    tick();
    set_r0(1'b1, 32'd10, 32'd20, ALU_ADD);
    r0_resp_ready = 1'b0;
    mid();
    chk("t4_r0_fill_ready", 32'(r0_ready), 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick();
      set_r0(1'b1, 32'd99, 32'd1, ALU_ADD);
      set_r1(1'b1, 32'(k), 32'hFF, ALU_XOR);
      mid();
      chk($sformatf("t4_r0_ready_%0d", k), 32'(r0_ready), 32'd0);
      chk($sformatf("t4_r1_ready_%0d", k), 32'(r1_ready), 32'd1);
      chk($sformatf("t4_r0_rvalid_%0d", k), 32'(r0_resp_valid), 32'd1);
      chk($sformatf("t4_r0_hold_%0d", k), r0_resp_data, 32'd30);
      if (k > 0) chk($sformatf("t4_r1_data_%0d", k), r1_resp_data, 32'(k - 1) ^ 32'hFF);
    end
    tick();
    r0_resp_ready = 1'b1;
    set_r0(1'b1, 32'd7, 32'd8, ALU_ADD);
    mid();
    chk("t4_refill_r0_ready", 32'(r0_ready), 32'd1);
    chk("t4_refill_r1_ready", 32'(r1_ready), 32'd0);
    chk("t4_refill_old_data", r0_resp_data, 32'd30);
    chk("t4_r1_data_last", r1_resp_data, 32'd2 ^ 32'hFF);
    tick(); r0_valid = 1'b0; r1_valid = 1'b0;
    mid();
    chk("t4_nobubble_rvalid", 32'(r0_resp_valid), 32'd1);
    chk("t4_refill_data", r0_resp_data, 32'd15);

    // 5: reset with r1 holding a result and r0 just accepted
    tick();
    set_r1(1'b1, 32'd3, 32'd4, ALU_ADD);
    r1_resp_ready = 1'b0;
    mid();
    chk("t5_r1_ready", 32'(r1_ready), 32'd1);
    tick();
    r1_valid = 1'b0;
    set_r0(1'b1, 32'd2, 32'd2, ALU_ADD);
    mid();
    chk("t5_r0_ready", 32'(r0_ready), 32'd1);
    chk("t5_r1_rvalid", 32'(r1_resp_valid), 32'd1);
    chk("t5_r1_rdata", r1_resp_data, 32'd7);
    tick();
    Reset = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1;
    mid();
    chk("t5_rst_r0_ready", 32'(r0_ready), 32'd0);
    chk("t5_rst_r1_ready", 32'(r1_ready), 32'd0);
    chk("t5_pre_r0_rdata", r0_resp_data, 32'd4);
    tick(); mid();
    chk("t5_r0_rvalid", 32'(r0_resp_valid), 32'd0);
    chk("t5_r1_rvalid_clr", 32'(r1_resp_valid), 32'd0);
    chk("t5_r0_rdata_clr", r0_resp_data, 32'h0);
    chk("t5_r1_rdata_clr", r1_resp_data, 32'h0);
    tick();
    Reset = 1'b0; r1_resp_ready = 1'b1;
    mid();
    chk("t5_ptr_r0_ready", 32'(r0_ready), 32'd1);
    chk("t5_ptr_r1_ready", 32'(r1_ready), 32'd0);

    // 6: idle cycles drive zeros and leave the pointer alone (r1 next)
    for (int k = 0; k < 2; k++) begin
      tick(); r0_valid = 1'b0; r1_valid = 1'b0;
      mid();
      chk($sformatf("t6_alu_A_%0d", k), alu_A, 32'h0);
      chk($sformatf("t6_alu_B_%0d", k), alu_B, 32'h0);
      chk($sformatf("t6_alu_op_%0d", k), 32'(alu_ALUop), 32'(ALU_IDLE_OP));
      chk($sformatf("t6_r0_ready_%0d", k), 32'(r0_ready), 32'd0);
      chk($sformatf("t6_r1_ready_%0d", k), 32'(r1_ready), 32'd0);
    end
    tick(); r0_valid = 1'b1; r1_valid = 1'b1;
    mid();
    chk("t6_ptr_r0_ready", 32'(r0_ready), 32'd0);
    chk("t6_ptr_r1_ready", 32'(r1_ready), 32'd1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
